// File: rtl/piso_stream.sv
// piso_stream: streams each wide FIFO word out as IN_W/OUT_W slices over valid/ready, with a one-word prefetch.
// Optional build macro PISO_STREAM_UNDERRUN_CNT_EN adds underrun_cnt.
module piso_stream #(
    parameter int IN_W      = 512,
    parameter int OUT_W     = 256,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [IN_W-1:0]  fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_re,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_first,
    output logic             o_last,
    output logic             busy
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
    ,
    output logic [31:0]      underrun_cnt
`endif
);
    localparam int R     = IN_W / OUT_W;
    localparam int IDX_W = (R > 2) ? $clog2(R) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

    generate
        if (R < 2 || (IN_W % OUT_W) != 0) begin : g_bad_ratio
            $error("piso_stream: IN_W must be an integer multiple (at least 2x) of OUT_W");
        end
    endgenerate

    logic [IN_W-1:0]  s_word;
    logic [IN_W-1:0]  p_word;
    logic             s_valid;
    logic             p_valid;
    logic             rd_pend;
    logic [IDX_W-1:0] idx;
    logic             at_last;
    logic             accept;
    logic             drain;
    logic             load_s;
    logic             load_p;
    logic [OUT_W-1:0] slices [R];

    assign at_last = (idx == IDX_LAST);
    assign accept  = s_valid & o_ready & ce;
    assign drain   = accept & at_last;
    assign fifo_re = ce & ~fifo_empty & ~rst & ~rd_pend & (~p_valid | ~s_valid | drain);

    // Returning read data never waits on ce: it goes to S when S is free
    // (or finishing now) and P is empty, otherwise it parks in P.
    assign load_s = rd_pend & (~s_valid | drain) & ~p_valid;
    assign load_p = rd_pend & ~load_s;

    for (genvar k = 0; k < R; k++) begin : g_slice
        if (MSB_FIRST) begin : g_msb
            assign slices[k] = s_word[IN_W-1-k*OUT_W -: OUT_W];
        end else begin : g_lsb
            assign slices[k] = s_word[k*OUT_W +: OUT_W];
        end
    end

    assign o_data  = slices[idx];
    assign o_valid = s_valid;
    assign o_first = s_valid & (idx == '0);
    assign o_last  = s_valid & at_last;
    assign busy    = s_valid | p_valid | rd_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_word  <= '0;
            p_word  <= '0;
            s_valid <= 1'b0;
            p_valid <= 1'b0;
            rd_pend <= 1'b0;
            idx     <= '0;
        end else begin
            rd_pend <= fifo_re;
            if (load_s) begin
                s_word  <= fifo_dout;
                s_valid <= 1'b1;
                idx     <= '0;
            end else if (drain) begin
                idx <= '0;
                if (p_valid) begin
                    s_word <= p_word;
                end else begin
                    s_valid <= 1'b0;
                end
            end else if (accept) begin
                idx <= idx + IDX_W'(1);
            end
            if (load_p) begin
                p_word  <= fifo_dout;
                p_valid <= 1'b1;
            end else if (drain & p_valid) begin
                p_valid <= 1'b0;
            end
        end
    end

`ifdef PISO_STREAM_UNDERRUN_CNT_EN
    // Starved cycles only count once the stream has actually started.
    logic seen_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            seen_accept  <= 1'b0;
        end else begin
            if (accept) begin
                seen_accept <= 1'b1;
            end
            if (ce & o_ready & ~s_valid & seen_accept & ~(&underrun_cnt)) begin
                underrun_cnt <= underrun_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream at IN_W=96/OUT_W=32 (R=3); a second instance with MSB_FIRST=0 shares all inputs.
// Expected slices come from a word-level scoreboard fed by a simple FIFO model.
module tb_piso_stream;
    localparam int IN_W  = 96;
    localparam int OUT_W = 32;
    localparam int R     = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             o_ready;
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_dout = '0;
    logic             fifo_re, fifo_re_l;
    logic [OUT_W-1:0] o_data, o_data_l;
    logic             o_valid, o_valid_l;
    logic             o_first, o_first_l;
    logic             o_last, o_last_l;
    logic             busy, busy_l;
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
    logic [31:0]      underrun_cnt, underrun_cnt_l;
    logic [31:0]      m_under;
    logic             m_seen;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [IN_W-1:0] mem [0:4095];
    int              wr_ptr = 0;
    int              rd_ptr = 0;
    logic [IN_W-1:0] exp_q [$];
    int              pos = 0;

    always #5 clk = ~clk;

    piso_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .o_first(o_first), .o_last(o_last), .busy(busy)
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    piso_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ce(ce), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re_l), .o_data(o_data_l), .o_valid(o_valid_l), .o_ready(o_ready),
        .o_first(o_first_l), .o_last(o_last_l), .busy(busy_l)
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt_l)
`endif
    );

    // Standard FIFO: data appears the cycle after the read strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_re) begin
            fifo_dout <= mem[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

`ifdef PISO_STREAM_UNDERRUN_CNT_EN
    always @(posedge clk) begin
        if (rst) begin
            m_under <= '0;
            m_seen  <= 1'b0;
        end else begin
            if (ce && o_ready && !o_valid && m_seen && m_under != 32'hFFFF_FFFF) m_under <= m_under + 32'd1;
            if (ce && o_ready && o_valid) m_seen <= 1'b1;
        end
    end
`endif

    function automatic logic [OUT_W-1:0] msb_slice(input logic [IN_W-1:0] w, input int k);
        return OUT_W'(w >> (OUT_W * (R - 1 - k)));
    endfunction

    function automatic logic [OUT_W-1:0] lsb_slice(input logic [IN_W-1:0] w, input int k);
        return OUT_W'(w >> (OUT_W * k));
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic push(input logic [IN_W-1:0] w);
        mem[wr_ptr % 4096] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
        exp_q.delete();
        pos = 0;
    endtask

    task automatic cyc(input logic rdy, input logic cev);
        @(negedge clk);
        o_ready = rdy;
        ce      = cev;
        #1;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1);
        push(rand_word());
        #1;
        n_cmp++;
        if (fifo_re !== 1'b0) begin n_err++; $display("FAIL reset_re got=%b want=0", fifo_re); end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if ({o_valid, o_first, o_last, busy, fifo_re} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got=%b want=00000", {o_valid, o_first, o_last, busy, fifo_re});
        end
        n_cmp++;
        if (o_data !== '0 || o_data_l !== '0) begin n_err++; $display("FAIL reset_data got=%h/%h want=0", o_data, o_data_l); end
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
        n_cmp++;
        if (underrun_cnt !== 32'd0) begin n_err++; $display("FAIL reset_underrun got=%0d want=0", underrun_cnt); end
`endif
        flush();
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (fifo_re !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_release got=re%b busy%b want=0", fifo_re, busy); end
    endtask

    task automatic test_latency();
        logic [IN_W-1:0] w;
        w = {32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h5555_5555};
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (fifo_re !== 1'b0) begin n_err++; $display("FAIL lat_idle_re got=%b want=0", fifo_re); end
        push(w);
        #1;
        n_cmp++;
        if (fifo_re !== 1'b1) begin n_err++; $display("FAIL lat_re_c got=%b want=1", fifo_re); end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL lat_c1 got=v%b busy%b want=v0 busy1", o_valid, busy); end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (!(o_valid === 1'b1 && o_first === 1'b1 && o_last === 1'b0 && o_data === 32'hAAAA_AAAA && o_data_l === 32'h5555_5555)) begin
            n_err++; $display("FAIL lat_c2 got=v%b f%b l%b %h/%h want=v1 f1 l0 aaaaaaaa/55555555", o_valid, o_first, o_last, o_data, o_data_l);
        end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b1 || o_first !== 1'b0 || o_last !== 1'b0 || o_data !== 32'h0F0F_0F0F) begin
            n_err++; $display("FAIL lat_c3 got=v%b f%b l%b %h want=v1 f0 l0 0f0f0f0f", o_valid, o_first, o_last, o_data);
        end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b1 || o_last !== 1'b1 || o_data !== 32'h5555_5555 || o_data_l !== 32'hAAAA_AAAA) begin
            n_err++; $display("FAIL lat_c4 got=v%b l%b %h/%h want=v1 l1 55555555/aaaaaaaa", o_valid, o_last, o_data, o_data_l);
        end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL lat_end got=v%b busy%b want=0", o_valid, busy); end
        exp_q.delete();
        pos = 0;
    endtask

    task automatic test_throughput();
        int n_slice = 0;
        int re_t [$];
        bit ended = 0;
        bit gap = 0;
        cyc(1'b1, 1'b1);
        repeat (8) push(rand_word());
        #1;
        for (int t = 0; t < 40; t++) begin
            if (t > 0) cyc(1'b1, 1'b1);
            if (fifo_re) re_t.push_back(t);
            if (o_valid) begin
                if (ended) gap = 1;
                n_slice++;
                n_cmp++;
                if (exp_q.size() == 0 || o_data !== msb_slice(exp_q[0], pos) || o_first !== (pos == 0) || o_last !== (pos == R - 1)) begin
                    n_err++; $display("FAIL thr_data got=%h f%b l%b want=slice %0d of next word", o_data, o_first, o_last, pos);
                end
                pos++;
                if (pos == R) begin pos = 0; if (exp_q.size() != 0) void'(exp_q.pop_front()); end
            end else if (n_slice > 0) begin
                ended = 1;
            end
        end
        n_cmp++;
        if (n_slice != 8 * R || gap) begin n_err++; $display("FAIL thr_count got=%0d gap=%0d want=%0d gap=0", n_slice, gap, 8 * R); end
        n_cmp++;
        if (re_t.size() != 8) begin n_err++; $display("FAIL thr_re_count got=%0d want=8", re_t.size()); end
        for (int i = 3; i < re_t.size(); i++) begin
            n_cmp++;
            if (re_t[i] - re_t[i-1] != R) begin n_err++; $display("FAIL thr_re_spacing got=%0d want=%0d", re_t[i] - re_t[i-1], R); end
        end
    endtask

    task automatic test_backpressure();
        int n_re = 0;
        int n_slice = 0;
        logic [OUT_W-1:0] held = '0;
        bit have = 0;
        cyc(1'b0, 1'b1);
        repeat (6) push(rand_word());
        #1;
        for (int t = 0; t < 20; t++) begin
            if (t > 0) cyc(1'b0, 1'b1);
            if (fifo_re) n_re++;
            if (o_valid) begin
                if (have) begin
                    n_cmp++;
                    if (o_data !== held || o_first !== 1'b1) begin n_err++; $display("FAIL bp_hold got=%h f%b want=%h f1", o_data, o_first, held); end
                end
                held = o_data;
                have = 1;
            end
        end
        n_cmp++;
        if (n_re != 2) begin n_err++; $display("FAIL bp_re_count got=%0d want=2", n_re); end
        n_cmp++;
        if (o_valid !== 1'b1 || held !== msb_slice(exp_q[0], 0)) begin n_err++; $display("FAIL bp_first got=v%b %h want=v1 %h", o_valid, held, msb_slice(exp_q[0], 0)); end
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            cyc(1'b1, 1'b1);
            if (o_valid) begin
                n_slice++;
                n_cmp++;
                if (o_data !== msb_slice(exp_q[0], pos) || o_data_l !== lsb_slice(exp_q[0], pos) || o_last !== (pos == R - 1)) begin
                    n_err++; $display("FAIL bp_data got=%h/%h want=%h/%h", o_data, o_data_l, msb_slice(exp_q[0], pos), lsb_slice(exp_q[0], pos));
                end
                pos++;
                if (pos == R) begin pos = 0; void'(exp_q.pop_front()); end
            end
        end
        n_cmp++;
        if (n_slice != 6 * R) begin n_err++; $display("FAIL bp_drain got=%0d want=%0d", n_slice, 6 * R); end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got=v%b busy%b want=0", o_valid, busy); end
    endtask

    task automatic test_reset_mid();
        logic [IN_W-1:0] w;
        bit found = 0;
        cyc(1'b1, 1'b1);
        repeat (3) push(rand_word());
        #1;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(1'b1, 1'b1);
            if (o_first) found = 1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL rstmid_start got=no first slice want=first slice within 8 cycles"); end
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (o_valid !== 1'b1 || o_first !== 1'b0 || o_last !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid_idx1 got=v%b f%b l%b busy%b want=v1 f0 l0 busy1", o_valid, o_first, o_last, busy);
        end
        rst = 1'b1;
        flush();
        #1;
        n_cmp++;
        if (fifo_re !== 1'b0) begin n_err++; $display("FAIL rstmid_re got=%b want=0", fifo_re); end
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || busy !== 1'b0 || o_first !== 1'b0) begin n_err++; $display("FAIL rstmid_after got=v%b busy%b f%b want=0", o_valid, busy, o_first); end
        w = rand_word();
        cyc(1'b1, 1'b1);
        push(w);
        #1;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            cyc(1'b1, 1'b1);
            if (o_valid) begin
                found = 1;
                n_cmp++;
                if (o_first !== 1'b1 || o_data !== msb_slice(w, 0)) begin n_err++; $display("FAIL rstmid_next got=f%b %h want=f1 %h", o_first, o_data, msb_slice(w, 0)); end
            end
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL rstmid_timeout got=no valid want=valid within 6 cycles"); end
        repeat (R + 2) cyc(1'b1, 1'b1);
        exp_q.delete();
        pos = 0;
    endtask

    task automatic test_random();
        int pushed = 0;
        int t = 0;
        logic stall_prev = 1'b0;
        logic [OUT_W-1:0] data_prev = '0;
        logic rdy, cev;
        exp_q.delete();
        pos = 0;
        while ((pushed < 1000 || exp_q.size() != 0) && t < 20000) begin
            rdy = ($urandom_range(1) == 1);
            cev = ($urandom_range(7) != 0);
            cyc(rdy, cev);
            if (pushed < 1000 && $urandom_range(1) == 1) begin push(rand_word()); pushed++; end
            #1;
            if (stall_prev) begin
                n_cmp++;
                if (o_valid !== 1'b1 || o_data !== data_prev) begin n_err++; $display("FAIL rnd_hold got=v%b %h want=v1 %h", o_valid, o_data, data_prev); end
            end
            n_cmp++;
            if (fifo_re_l !== fifo_re || o_valid_l !== o_valid) begin n_err++; $display("FAIL rnd_pair got=%b%b want=%b%b", fifo_re_l, o_valid_l, fifo_re, o_valid); end
            if (o_valid && o_ready && ce) begin
                n_cmp++;
                if (exp_q.size() == 0 || o_data !== msb_slice(exp_q[0], pos) || o_data_l !== lsb_slice(exp_q[0], pos)
                    || o_first !== (pos == 0) || o_last !== (pos == R - 1) || o_first_l !== o_first || o_last_l !== o_last) begin
                    n_err++; $display("FAIL rnd_data got=%h/%h f%b l%b want=slice %0d (left %0d words)", o_data, o_data_l, o_first, o_last, pos, exp_q.size());
                end
                pos++;
                if (pos == R) begin pos = 0; if (exp_q.size() != 0) void'(exp_q.pop_front()); end
            end
            stall_prev = o_valid && !(o_ready && ce);
            data_prev  = o_data;
            t++;
        end
        n_cmp++;
        if (t >= 20000) begin n_err++; $display("FAIL rnd_timeout got=%0d words left want=0", exp_q.size()); end
        repeat (3) cyc(1'b1, 1'b1);
        n_cmp++;
        if (busy !== 1'b0 || busy_l !== 1'b0) begin n_err++; $display("FAIL rnd_idle got=%b%b want=00", busy, busy_l); end
    endtask

`ifdef PISO_STREAM_UNDERRUN_CNT_EN
    task automatic test_underrun();
        cyc(1'b1, 1'b1);
        rst = 1'b1;
        flush();
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        repeat (3) cyc(1'b1, 1'b1);
        push(rand_word());
        push(rand_word());
        #1;
        cyc(1'b1, 1'b1);
        n_cmp++;
        if (underrun_cnt !== 32'd0) begin n_err++; $display("FAIL und_before_start got=%0d want=0", underrun_cnt); end
        repeat (12) cyc(1'b1, 1'b1);
        n_cmp++;
        if (underrun_cnt !== m_under) begin n_err++; $display("FAIL und_gap got=%0d want=%0d", underrun_cnt, m_under); end
        push(rand_word());
        #1;
        repeat (3) cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b1, 1'b1);
        n_cmp++;
        if (underrun_cnt !== m_under || underrun_cnt_l !== m_under) begin
            n_err++; $display("FAIL und_end got=%0d/%0d want=%0d", underrun_cnt, underrun_cnt_l, m_under);
        end
        exp_q.delete();
        pos = 0;
    endtask
`endif

    initial begin
        rst     = 1'b1;
        ce      = 1'b0;
        o_ready = 1'b0;
        test_reset();
        test_latency();
        test_throughput();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef PISO_STREAM_UNDERRUN_CNT_EN
        test_underrun();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
